vector_operand_fetch: RTL and testbench

Sequencer that streams operand pairs out of the 512×24-bit dual-read-port memory unit for the vector ALU. It accepts a start command with two base addresses and a vector length. It drives both memory read addresses each cycle and returns the operand pairs over a valid/ready stream. It sits between the vector control unit and the memory unit and is the only block that owns the memory unit's two read-address inputs.

---
 rtl/vm_pkg.sv | 21 ++
 rtl/vof_addr_gen.sv | 75 +++++++
 rtl/vector_operand_fetch.sv | 122 ++++++++++++
 tb/tb_vector_operand_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared vector-memory definitions used by the operand fetch, memory unit and ALU.
// Widths, memory depth, fetch FSM state encoding and the length clamp helper.
package vm_pkg;

    localparam int WORD_W    = 24;
    localparam int ADDR_W    = 9;
    localparam int LEN_W     = 10;
    localparam int MEM_DEPTH = 512;

    typedef enum logic [1:0] {
        VOF_IDLE,
        VOF_RUN,
        VOF_FLUSH,
        VOF_DONE
    } vof_state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : len;
    endfunction

endpackage

// File: rtl/vof_addr_gen.sv
// Address/count generator for vector_operand_fetch: two wrapping read pointers
// and the remaining-element counter. VOF_STRIDE_EN adds a latched 4-bit stride.
module vof_addr_gen
    import vm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic [LEN_W-1:0]  len_i,
`ifdef VOF_STRIDE_EN
    input  logic [3:0]        stride_i,
`endif
    output logic [ADDR_W-1:0] addr1_o,
    output logic [ADDR_W-1:0] addr2_o,
    output logic [LEN_W-1:0]  remaining_o
);

    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] inc;

`ifdef VOF_STRIDE_EN
    logic [3:0] stride_q, stride_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stride_q <= '0;
        else        stride_q <= stride_d;
    end

    assign stride_d = load_i ? stride_i : stride_q;
    assign inc      = ADDR_W'(stride_q);
`else
    assign inc      = ADDR_W'(1);
`endif

    // Pointer sums are ADDR_W wide, so 511 + inc wraps to the bottom for free.
    always_comb begin
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        rem_d   = rem_q;
        if (clr_i) begin
            rem_d = '0;
        end else if (load_i) begin
            addr1_d = base_a_i;
            addr2_d = base_b_i;
            rem_d   = clamp_len(len_i);
        end else if (step_i) begin
            addr1_d = addr1_q + inc;
            addr2_d = addr2_q + inc;
            rem_d   = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr1_q <= '0;
            addr2_q <= '0;
            rem_q   <= '0;
        end else begin
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            rem_q   <= rem_d;
        end
    end

    assign addr1_o     = addr1_q;
    assign addr2_o     = addr2_q;
    assign remaining_o = rem_q;

endmodule

// File: rtl/vector_operand_fetch.sv
// Streams operand pairs from the dual-read vector memory to the vector ALU.
// Define VOF_STRIDE_EN to add the per-command stride port.
module vector_operand_fetch
    import vm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  length,
`ifdef VOF_STRIDE_EN
    input  logic [3:0]        stride,
`endif
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    input  logic [WORD_W-1:0] mem_data1,
    input  logic [WORD_W-1:0] mem_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_a,
    output logic [WORD_W-1:0] out_b,
    output logic              out_last
);

    vof_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic              cmd_load, step, clr;
    logic [LEN_W-1:0]  remaining;

    vof_addr_gen u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (cmd_load),
        .step_i      (step),
        .clr_i       (clr),
        .base_a_i    (base_a),
        .base_b_i    (base_b),
        .len_i       (length),
`ifdef VOF_STRIDE_EN
        .stride_i    (stride),
`endif
        .addr1_o     (mem_addr1),
        .addr2_o     (mem_addr2),
        .remaining_o (remaining)
    );

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        cmd_load = 1'b0;
        step     = 1'b0;
        clr      = 1'b0;
        if (abort) begin
            state_d = VOF_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                VOF_IDLE: begin
                    if (start) begin
                        cmd_load = 1'b1;
                        state_d  = (length == '0) ? VOF_DONE : VOF_RUN;
                    end
                end
                VOF_RUN: begin
                    // Output register refills whenever it is empty or being drained.
                    if (!valid_q || out_ready) begin
                        a_d     = mem_data1;
                        b_d     = mem_data2;
                        valid_d = 1'b1;
                        last_d  = (remaining == LEN_W'(1));
                        step    = 1'b1;
                        if (remaining == LEN_W'(1)) state_d = VOF_FLUSH;
                    end
                end
                VOF_FLUSH: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = VOF_DONE;
                    end
                end
                VOF_DONE: state_d = VOF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VOF_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy      = (state_q != VOF_IDLE);
    assign done      = (state_q == VOF_DONE);
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_a     = a_q;
    assign out_b     = b_q;

endmodule

// File: tb/tb_vector_operand_fetch.sv
// Self-checking bench for vector_operand_fetch against a queue-based reference.
// Build with VOF_STRIDE_EN defined to exercise the stride port as well.
module tb_vector_operand_fetch;
    import vm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_a, base_b;
    logic [LEN_W-1:0]  length;
`ifdef VOF_STRIDE_EN
    logic [3:0]        stride;
`endif
    logic              abort;
    logic              busy, done;
    logic [ADDR_W-1:0] mem_addr1, mem_addr2;
    logic [WORD_W-1:0] mem_data1, mem_data2;
    logic              out_valid, out_ready;
    logic [WORD_W-1:0] out_a, out_b;
    logic              out_last;

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    int tests = 0;
    int fails = 0;

    vector_operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_a    (base_a),
        .base_b    (base_b),
        .length    (length),
`ifdef VOF_STRIDE_EN
        .stride    (stride),
`endif
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_addr1 (mem_addr1),
        .mem_addr2 (mem_addr2),
        .mem_data1 (mem_data1),
        .mem_data2 (mem_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last)
    );

    assign mem_data1 = mem[mem_addr1];
    assign mem_data2 = mem[mem_addr2];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_vec(input int ba, input int bb, input int len,
                           input int mode, input int st, input int abort_after);
        logic [WORD_W-1:0] qa[$];
        logic [WORD_W-1:0] qb[$];
        int n, k, hs, dones, budget, exp_done;
        bit prev_stall, saw_done, just_hs;
        logic [WORD_W-1:0] pa, pb;
        logic pl;
        n = (len > MEM_DEPTH) ? MEM_DEPTH : len;
        for (int i = 0; i < n; i++) begin
            qa.push_back(mem[(ba + i * st) % MEM_DEPTH]);
            qb.push_back(mem[(bb + i * st) % MEM_DEPTH]);
        end
        base_a = ADDR_W'(ba);
        base_b = ADDR_W'(bb);
        length = LEN_W'(len);
`ifdef VOF_STRIDE_EN
        stride = 4'(st);
`endif
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_a = ADDR_W'($urandom);
        base_b = ADDR_W'($urandom);
        length = LEN_W'($urandom);
        chk("busy_after_start", 32'(busy), 1);
        chk("valid_after_start", 32'(out_valid), 0);
        chk("addr1_first", 32'(mem_addr1), ba % MEM_DEPTH);
        chk("addr2_first", 32'(mem_addr2), bb % MEM_DEPTH);
        k = 0; hs = 0; dones = 0; prev_stall = 0; saw_done = 0;
        pa = '0; pb = '0; pl = 1'b0;
        budget = 4 * n + 20;
        exp_done = (n == 0) ? 0 : n + 1;
        while (k < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (mode == 0 && n > 0 && k <= n)
                chk("addr1_seq", 32'(mem_addr1), (ba + k * st) % MEM_DEPTH);
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_a", 32'(out_a), 32'(pa));
                chk("hold_b", 32'(out_b), 32'(pb));
                chk("hold_last", 32'(out_last), 32'(pl));
            end
            just_hs = 0;
            if (out_valid && out_ready) begin
                if (hs < n) begin
                    chk("pair_a", 32'(out_a), 32'(qa[hs]));
                    chk("pair_b", 32'(out_b), 32'(qb[hs]));
                    chk("pair_last", 32'(out_last), (hs == n - 1) ? 1 : 0);
                end else begin
                    chk("extra_pair", hs, n);
                end
                if (mode == 0) chk("hs_timing", k, hs + 1);
                hs++;
                just_hs = 1;
            end
            if (done) begin
                dones++;
                saw_done = 1;
                chk("valid_in_done", 32'(out_valid), 0);
                if (mode == 0) chk("done_timing", k, exp_done);
            end
            if (just_hs && abort_after >= 0 && hs == abort_after) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                out_ready = 1'b0;
                chk("abort_valid", 32'(out_valid), 0);
                chk("abort_last", 32'(out_last), 0);
                chk("abort_busy", 32'(busy), 0);
                for (int j = 0; j < 4; j++) begin
                    chk("abort_no_done", 32'(done), 0);
                    tick();
                end
                return;
            end
            prev_stall = out_valid && !out_ready;
            pa = out_a; pb = out_b; pl = out_last;
            tick();
            k++;
            if (saw_done) begin
                chk("done_low", 32'(done), 0);
                chk("idle_after", 32'(busy), 0);
                break;
            end
        end
        out_ready = 1'b0;
        chk("done_pulses", dones, 1);
        chk("handshakes", hs, n);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        base_a = '0;
        base_b = '0;
        length = '0;
`ifdef VOF_STRIDE_EN
        stride = 4'd1;
`endif
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = WORD_W'($urandom);
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_a", 32'(out_a), 0);
        chk("rst_b", 32'(out_b), 0);
        chk("rst_addr1", 32'(mem_addr1), 0);
        chk("rst_addr2", 32'(mem_addr2), 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_vec(0, 5, 4, 0, 1, -1);
        run_vec(0, 5, 4, 1, 1, -1);
        run_vec(510, 511, 3, 0, 1, -1);
        run_vec(510, 511, 3, 2, 1, -1);
        run_vec(17, 17, 6, 0, 1, -1);
        run_vec(40, 300, 0, 0, 1, -1);
        run_vec(3, 200, 600, 2, 1, -1);
        run_vec(100, 400, 8, 0, 1, 2);
        run_vec(100, 400, 8, 0, 1, -1);
        for (int r = 0; r < 6; r++)
            run_vec($urandom_range(0, 511), $urandom_range(0, 511),
                    $urandom_range(0, 40), 2, 1, -1);

        // start while busy must not disturb the running vector
        base_a = 9'd20; base_b = 9'd30; length = 10'd5; start = 1'b1;
        tick();
        start = 1'b1;
        base_a = 9'd0;
        tick();
        start = 1'b0;
        chk("busy_ignore_start", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'(busy), 0);

`ifdef VOF_STRIDE_EN
        run_vec(0, 7, 4, 0, 3, -1);
        run_vec(500, 9, 5, 2, 15, -1);
        run_vec(33, 44, 3, 0, 0, -1);
`endif

        // asynchronous reset mid-vector
        base_a = 9'd50; base_b = 9'd60; length = 10'd8; out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_reset_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_last", 32'(out_last), 0);
        chk("arst_a", 32'(out_a), 0);
        chk("arst_b", 32'(out_b), 0);
        chk("arst_addr1", 32'(mem_addr1), 0);
        chk("arst_addr2", 32'(mem_addr2), 0);
        out_ready = 1'b0;
        tick();
        chk("arst_no_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();
        run_vec(7, 8, 5, 1, 1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
